memory_stage: RTL

- Pipeline stage directly downstream of execute_stage.
- Takes one resolved instruction per cycle: ALU result, load or store.
- Issues word accesses to the data memory over a strobe/valid handshake.
- Drives the register-file write port (wr_addr/wr_data) and the second forwarding port (fwd_b_addr/fwd_b_val). Backpressures execute via mem_stall.

---
 rtl/cs3220_pkg.sv | 20 ++
 rtl/memory_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/cs3220_pkg.sv
// Shared types and widths for the cs3220 pipeline stages.
package cs3220_pkg;

  localparam int REG_W = 4;
  localparam int XLEN  = 32;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_NOP   = 2'd3
  } exec_kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/memory_stage.sv
// Memory pipeline stage: retires ALU results, runs word loads/stores over a
// strobe/valid data-memory handshake and drives the register-file write port.
//
// state | meaning
// IDLE  | accepting instructions; ALU/NOP/misaligned retire here
// REQ   | one-cycle request strobe on the data-memory bus
// WAIT  | request held stable, waiting for response or timeout
module memory_stage
  import cs3220_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = 7
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              exec_valid,
  input  logic [1:0]        exec_kind,
  input  logic [REG_W-1:0]  exec_rd,
  input  logic [XLEN-1:0]   exec_result,
  input  logic [XLEN-1:0]   exec_store_data,
  output logic              mem_stall,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic              dmem_req_stb,
  output logic              dmem_req_we,
  output logic [XLEN-1:0]   dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [XLEN-1:0]   dmem_resp_data,
  output logic [REG_W-1:0]  wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic [REG_W-1:0]  fwd_b_addr,
  output logic [XLEN-1:0]   fwd_b_val,
  output logic              mem_misalign,
  output logic              mem_fault
);

  mem_state_t       state;
  logic [TMR_W-1:0] timer;
  logic [REG_W-1:0] rd_q;
  exec_kind_t       kind;

  assign kind       = exec_kind_t'(exec_kind);
  assign mem_stall  = (state != IDLE);
  assign fwd_b_addr = wr_addr;
  assign fwd_b_val  = wr_data;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      timer          <= '0;
      rd_q           <= '0;
      dmem_req_addr  <= '0;
      dmem_req_stb   <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_wdata <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
      mem_misalign   <= 1'b0;
      mem_fault      <= 1'b0;
    end else begin
      wr_addr      <= '0;
      mem_misalign <= 1'b0;
      dmem_req_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (exec_valid) begin
            case (kind)
              KIND_ALU: begin
                wr_addr <= exec_rd;
                wr_data <= exec_result;
              end
              KIND_LOAD, KIND_STORE: begin
                if (exec_result[1:0] != 2'b00) begin
                  mem_misalign <= 1'b1;
                end else begin
                  state          <= REQ;
                  dmem_req_stb   <= 1'b1;
                  dmem_req_addr  <= exec_result;
                  dmem_req_we    <= (kind == KIND_STORE);
                  dmem_req_wdata <= exec_store_data;
                  rd_q           <= exec_rd;
                end
              end
              default: ;
            endcase
          end
        end
        REQ, WAIT: begin
          // A response arriving during the strobe cycle completes immediately.
          if (dmem_resp_valid) begin
            if (!dmem_req_we) begin
              wr_addr <= rd_q;
              wr_data <= dmem_resp_data;
            end
            state <= IDLE;
            timer <= '0;
          end else if (state == REQ) begin
            state <= WAIT;
            timer <= '0;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            mem_fault <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
